// File: rtl/display_scheduler.sv
// display_scheduler: shares the 8-digit 7-segment display between live time,
// edit mode (with per-digit blinking) and timed one-shot messages.
module display_scheduler #(
    parameter int unsigned CLK_FREQ_HZ = 1000,
    parameter int unsigned BLINK_HZ    = 2,
    parameter int unsigned MSG_HOLD_MS = 2000,
    parameter logic [3:0]  BLANK_CODE  = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] time_data,
    input  logic        edit_req,
    input  logic [31:0] edit_data,
    input  logic [7:0]  edit_blink,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
    output logic        msg_ready,
    output logic        msg_done,
    output logic [31:0] all_data,
    output logic [1:0]  src_sel
);

    localparam logic [31:0] HALF_CYC = 32'(CLK_FREQ_HZ / (2 * BLINK_HZ));
    localparam logic [31:0] MSG_CYC  = 32'((CLK_FREQ_HZ / 1000) * MSG_HOLD_MS);

    // Encoding doubles as the src_sel owner code.
    typedef enum logic [1:0] {
        SHOW_TIME = 2'd0,
        SHOW_EDIT = 2'd1,
        SHOW_MSG  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_pending;
    logic [31:0] r_msg_buf;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_blink_cnt;
    logic        r_blink_off;
    logic [7:0]  r_prev_blink;
    logic [31:0] r_all_data;
    logic        r_msg_done;

    logic        w_accept;
    logic        w_done;
    logic        w_blink_restart;
    logic [31:0] w_blink_cnt_nxt;
    logic        w_blink_off_nxt;
    logic [31:0] w_msg_src;
    logic [31:0] w_data_nxt;

    // Replace blinking digits by BLANK_CODE during the OFF phase.
    function automatic logic [31:0] blink_mask(input logic [31:0] data,
                                               input logic [7:0]  mask,
                                               input logic        off);
        logic [31:0] res;
        res = data;
        for (int i = 0; i < 8; i++) begin
            if (off && mask[i]) res[4*i +: 4] = BLANK_CODE;
        end
        return res;
    endfunction

    assign w_accept  = msg_valid & ~r_pending;
    assign w_done    = (r_state == SHOW_MSG) && (r_hold_cnt == MSG_CYC - 32'd1);
    // A message accepted on this very edge is not in the buffer yet.
    assign w_msg_src = w_accept ? msg_data : r_msg_buf;

    // Next-state logic: edit preempts everything, a pending message resumes after edit.
    always_comb begin
        w_next = r_state;
        if (edit_req) begin
            w_next = SHOW_EDIT;
        end else begin
            case (r_state)
                SHOW_TIME: w_next = w_accept ? SHOW_MSG : SHOW_TIME;
                SHOW_EDIT: w_next = (r_pending || w_accept) ? SHOW_MSG : SHOW_TIME;
                SHOW_MSG:  w_next = w_done ? SHOW_TIME : SHOW_MSG;
                default:   w_next = SHOW_TIME;
            endcase
        end
    end

    // Blink phase and the display word selected by the next state.
    always_comb begin
        w_blink_restart = (r_state != SHOW_EDIT) || (edit_blink != r_prev_blink);
        w_blink_cnt_nxt = 32'd0;
        w_blink_off_nxt = 1'b0;
        if (w_next == SHOW_EDIT && !w_blink_restart) begin
            if (r_blink_cnt == HALF_CYC - 32'd1) begin
                w_blink_off_nxt = ~r_blink_off;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 32'd1;
                w_blink_off_nxt = r_blink_off;
            end
        end
        case (w_next)
            SHOW_EDIT: w_data_nxt = blink_mask(edit_data, edit_blink, w_blink_off_nxt);
            SHOW_MSG:  w_data_nxt = w_msg_src;
            default:   w_data_nxt = time_data;
        endcase
    end

    // State register and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= SHOW_TIME;
            r_all_data  <= 32'd0;
            r_msg_done  <= 1'b0;
            r_blink_cnt <= 32'd0;
            r_blink_off <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_all_data  <= w_data_nxt;
            r_msg_done  <= w_done;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_off <= w_blink_off_nxt;
        end
    end

    // Message buffer, pending flag, hold counter and blink-change history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending    <= 1'b0;
            r_msg_buf    <= 32'd0;
            r_hold_cnt   <= 32'd0;
            r_prev_blink <= 8'd0;
        end else begin
            r_prev_blink <= edit_blink;
            if (w_accept) begin
                r_pending  <= 1'b1;
                r_msg_buf  <= msg_data;
                r_hold_cnt <= 32'd0;
            end else begin
                if (w_done) r_pending <= 1'b0;
                // Only cycles actually spent showing the message count.
                if (r_state == SHOW_MSG && !w_done) r_hold_cnt <= r_hold_cnt + 32'd1;
            end
        end
    end

    assign msg_ready = ~r_pending;
    assign msg_done  = r_msg_done;
    assign all_data  = r_all_data;
    assign src_sel   = r_state;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed vector table, hand sequences for preemption
// and blinking, then randomized traffic against a behavioural model.
module tb_display_scheduler;

    localparam int HALF = 5;
    localparam int MCYC = 5;
    localparam logic [31:0] T = 32'h12345600;

    logic        clk;
    logic        reset;
    logic [31:0] time_data;
    logic        edit_req;
    logic [31:0] edit_data;
    logic [7:0]  edit_blink;
    logic        msg_valid;
    logic [31:0] msg_data;
    logic        msg_ready;
    logic        msg_done;
    logic [31:0] all_data;
    logic [1:0]  src_sel;

    int n_checks = 0;
    int n_errors = 0;

    display_scheduler #(
        .CLK_FREQ_HZ(1000), .BLINK_HZ(100), .MSG_HOLD_MS(5), .BLANK_CODE(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .time_data(time_data), .edit_req(edit_req),
        .edit_data(edit_data), .edit_blink(edit_blink), .msg_valid(msg_valid),
        .msg_data(msg_data), .msg_ready(msg_ready), .msg_done(msg_done),
        .all_data(all_data), .src_sel(src_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        er;
        logic [31:0] ed;
        logic [7:0]  eb;
        logic        mv;
        logic [31:0] md;
        logic [31:0] ea;
        logic [1:0]  es;
        logic        rdy;
        logic        dn;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic er, logic [31:0] ed, logic [7:0] eb, logic mv,
                                logic [31:0] md, logic [31:0] ea, logic [1:0] es,
                                logic rdy, logic dn);
        vec_t v;
        v.er = er; v.ed = ed; v.eb = eb; v.mv = mv; v.md = md;
        v.ea = ea; v.es = es; v.rdy = rdy; v.dn = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea, input logic [1:0] es,
                           input logic er, input logic ed);
        chk({tag, ".all_data"}, all_data, ea);
        chk({tag, ".src_sel"}, {30'd0, src_sel}, {30'd0, es});
        chk({tag, ".msg_ready"}, {31'd0, msg_ready}, {31'd0, er});
        chk({tag, ".msg_done"}, {31'd0, msg_done}, {31'd0, ed});
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: owner, pending message, visible-cycle count,
    // cycles since the blink pattern last restarted.
    int          m_own;
    bit          m_pend;
    logic [31:0] m_buf;
    int          m_shown;
    int          m_since;
    logic [7:0]  m_prevb;
    logic [31:0] m_all;
    bit          m_done;

    task automatic model_reset();
        m_own = 0; m_pend = 0; m_buf = 0; m_shown = 0; m_since = 0;
        m_prevb = 0; m_all = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit dn;
        int nown;
        bit off;
        acc = msg_valid && !m_pend;
        dn  = 0;
        if (m_own == 2) begin
            m_shown++;
            if (m_shown == MCYC) dn = 1;
        end
        if (dn) m_pend = 0;
        if (acc) begin
            m_pend = 1; m_buf = msg_data; m_shown = 0;
        end
        if (edit_req)        nown = 1;
        else if (m_own == 1) nown = m_pend ? 2 : 0;
        else if (m_own == 0) nown = acc ? 2 : 0;
        else                 nown = dn ? 0 : 2;
        if (nown == 1) begin
            if (m_own != 1 || edit_blink != m_prevb) m_since = 0;
            else m_since++;
        end else begin
            m_since = 0;
        end
        m_prevb = edit_blink;
        if (nown == 0) m_all = time_data;
        else if (nown == 2) m_all = m_buf;
        else begin
            off = ((m_since / HALF) % 2) == 1;
            for (int i = 0; i < 8; i++)
                m_all[4*i +: 4] = (off && edit_blink[i]) ? 4'hF : edit_data[4*i +: 4];
        end
        m_own  = nown;
        m_done = dn;
    endtask

    initial begin
        logic [31:0] exp_d;
        // Directed handshake table: single message, then a second offer held while pending.
        tbl[0] = mk(0, 0, 0, 0, 0, T, 0, 1, 0);
        tbl[1] = mk(0, 0, 0, 1, 32'hAAAA0001, 32'hAAAA0001, 2, 0, 0);
        for (int i = 2; i <= 5; i++) tbl[i] = mk(0, 0, 0, 0, 0, 32'hAAAA0001, 2, 0, 0);
        tbl[6] = mk(0, 0, 0, 0, 0, T, 0, 1, 1);
        tbl[7] = mk(0, 0, 0, 0, 0, T, 0, 1, 0);
        tbl[8] = mk(0, 0, 0, 1, 32'hBBBB0002, 32'hBBBB0002, 2, 0, 0);
        for (int i = 9; i <= 12; i++) tbl[i] = mk(0, 0, 0, 1, 32'hCCCC0003, 32'hBBBB0002, 2, 0, 0);
        tbl[13] = mk(0, 0, 0, 1, 32'hCCCC0003, T, 0, 1, 1);
        tbl[14] = mk(0, 0, 0, 1, 32'hCCCC0003, 32'hCCCC0003, 2, 0, 0);
        for (int i = 15; i <= 18; i++) tbl[i] = mk(0, 0, 0, 0, 0, 32'hCCCC0003, 2, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, T, 0, 1, 1);

        reset = 1'b0; time_data = T; edit_req = 0; edit_data = 0; edit_blink = 0;
        msg_valid = 0; msg_data = 0;
        #1 reset = 1'b1;
        #6;
        chk_all("reset", 32'd0, 2'd0, 1'b1, 1'b0);
        #1 reset = 1'b0;
        @(negedge clk);
        #3;

        for (int i = 0; i < 20; i++) begin
            edit_req = tbl[i].er; edit_data = tbl[i].ed; edit_blink = tbl[i].eb;
            msg_valid = tbl[i].mv; msg_data = tbl[i].md;
            edge1();
            chk_all($sformatf("row%0d", i), tbl[i].ea, tbl[i].es, tbl[i].rdy, tbl[i].dn);
        end
        msg_valid = 0;

        // Message preempted by edit after 2 cycles, resumes for the remaining 3.
        msg_valid = 1; msg_data = 32'hDDDD0004;
        edge1(); chk_all("pre.acc", 32'hDDDD0004, 2, 0, 0);
        msg_valid = 0;
        edge1(); chk_all("pre.show2", 32'hDDDD0004, 2, 0, 0);
        edit_req = 1; edit_data = 32'h00001259; edit_blink = 0;
        for (int k = 0; k < 10; k++) begin
            edge1(); chk_all($sformatf("pre.edit%0d", k), 32'h00001259, 1, 0, 0);
        end
        edit_req = 0;
        for (int k = 0; k < 3; k++) begin
            edge1(); chk_all($sformatf("pre.resume%0d", k), 32'hDDDD0004, 2, 0, 0);
        end
        edge1(); chk_all("pre.done", T, 0, 1, 1);

        // Blinking digits 0,1: 5 cycles ON / 5 cycles blanked.
        edit_req = 1; edit_blink = 8'h03;
        for (int k = 0; k < 27; k++) begin
            edge1();
            exp_d = (((k / HALF) % 2) == 1) ? 32'h000012FF : 32'h00001259;
            chk_all($sformatf("blink%0d", k), exp_d, 1, 1, 0);
        end
        // Mask change during OFF phase restarts with a full ON phase.
        edit_blink = 8'h0C;
        for (int k = 0; k < 10; k++) begin
            edge1();
            exp_d = (k < HALF) ? 32'h00001259 : 32'h0000FF59;
            chk_all($sformatf("rebl%0d", k), exp_d, 1, 1, 0);
        end
        edit_req = 0; edit_blink = 0;
        edge1(); chk_all("edit.exit", T, 0, 1, 0);

        // Randomized traffic against the model, with one reset mid-run.
        reset = 1'b1;
        #2;
        chk_all("rnd.reset", 32'd0, 0, 1, 0);
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0) edit_req = ~edit_req;
            if ($urandom_range(9) == 0) edit_blink = 8'($urandom);
            if ($urandom_range(19) == 0) edit_data = $urandom;
            msg_valid = ($urandom_range(3) == 0);
            msg_data  = $urandom;
            time_data = $urandom;
            edge1();
            model_step();
            chk_all($sformatf("rnd%0d", i), m_all, 2'(m_own), !m_pend, m_done);
            if (i == 700) begin
                reset = 1'b1;
                #2;
                chk_all("rnd.midreset", 32'd0, 0, 1, 0);
                model_reset();
                reset = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
